mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-stage access controller: consumes the execute-stage results (ALU result as address,
//  store data, zero flag) and performs LDUR/STUR doubleword accesses on a handshaked data-memory
//  port. Holds the pipeline via stall_M for multi-cycle accesses, and resolves the CBZ/B branch
//  select from Branch_M & zero_M. Sits between execute and writeback.
// PARAMETERS
//  DM_ADDR_W   6    data-memory doubleword address width (2^6 = 64 entries)
//  TIMEOUT     16   max cycles in REQ without dm_ack before abort (>=1)
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-low reset
//  MemRead_M    in   1    load request (LDUR)
//  MemWrite_M   in   1    store request (STUR)
//  Branch_M     in   1    conditional-branch instruction
//  zero_M       in   1    ALU zero flag from execute
//  aluResult_M  in   64   effective byte address
//  writeData_M  in   64   store data
//  readData_M   out  64   load data, registered
//  PCSrc_M      out  1    Branch_M & zero_M, combinational
//  stall_M      out  1    1 = hold the PC and all upstream pipeline registers
//  memDone_M    out  1    1-cycle pulse: access finished (ok, timeout or misaligned)
//  misalign_M   out  1    1-cycle pulse: aluResult_M[2:0] != 0, no bus access made
//  timeout_M    out  1    1-cycle pulse: access aborted after TIMEOUT cycles
//  dm_req       out  1    bus request, held until dm_ack
//  dm_we        out  1    1 = write, 0 = read; stable while dm_req
//  dm_addr      out  DM_ADDR_W  aluResult_M[DM_ADDR_W+2:3], latched at request
//  dm_wdata     out  64   latched store data
//  dm_ack       in   1    bus accepts/completes the access this cycle
//  dm_rdata     in   64   read data, valid when dm_ack & ~dm_we
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, count=0, readData_M=0, dm_req=0, dm_we=0, dm_addr=0,
//   dm_wdata=0, memDone_M=misalign_M=timeout_M=0. dm_req drops immediately, mid-access included.
//  access = MemRead_M|MemWrite_M. Both set = write; the read is ignored.
//  FSM IDLE/REQ/DONE:
//   IDLE: no access -> stay, stall_M=0. Access with aluResult_M[2:0]!=0 -> DONE, misalign_M and
//    memDone_M pulse in the DONE cycle, no dm_req. Aligned access -> latch addr/data/we into the
//    dm_* registers -> REQ. stall_M=1 combinationally in the IDLE cycle that sees an aligned
//    access.
//   REQ: dm_req=1, stall_M=1, count++. dm_ack=1 -> capture dm_rdata into readData_M (reads
//    only; writes keep readData_M) -> DONE. count reaches TIMEOUT with no ack -> drop dm_req,
//    readData_M=0 -> DONE, timeout_M pulses.
//   DONE: stall_M=0, memDone_M=1 -> IDLE, count=0. The pipeline advances this cycle, so the
//    same instruction is never reissued.
//  Latency: minimum 3 cycles IDLE->REQ->DONE with a zero-wait ack (ack in the first REQ cycle).
//   Read data is visible in DONE.
//  Address bits above DM_ADDR_W+2 are ignored: the address wraps modulo 2^DM_ADDR_W
//   doublewords.
//  dm_ack outside REQ is ignored. PCSrc_M is independent of the FSM.
// TESTING
//  1 Read, ack 3 cycles after req: aluResult=0x28, MemRead=1 -> dm_addr=5, dm_we=0; stall for
//    4 cycles; dm_rdata=0xDEADBEEF -> readData_M=0xDEADBEEF, memDone_M pulses in DONE.
//  2 Zero-wait write: aluResult=0x10, writeData=0x1234, MemWrite=1, dm_ack held 1 -> dm_addr=2,
//    dm_we=1, dm_wdata=0x1234; memDone_M 2 cycles after IDLE; readData_M unchanged.
//  3 Misaligned: aluResult=0x0C, MemRead=1 -> misalign_M=1, memDone_M=1, dm_req never 1.
//  4 Timeout: MemRead=1, dm_ack=0 -> dm_req high 16 cycles, then timeout_M=1, readData_M=0,
//    stall_M falls.
//  5 Reset mid-REQ: reset=0 in the 2nd REQ cycle -> dm_req=0, stall_M=0, all outputs 0
//    without waiting for a clock edge.
//  6 Branch/wrap: Branch_M=1, zero_M=1 -> PCSrc_M=1; zero_M=0 -> 0; aluResult=0x208 read
//    -> dm_addr=1.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller.
// Runs LDUR/STUR doubleword accesses on a handshaked data-memory port. It holds the
// pipeline while an access is outstanding, aborts accesses the bus never acknowledges,
// and resolves the CBZ/B branch select.
module mem_access_ctrl #(
    parameter int DM_ADDR_W = 6,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemRead_M,
    input  logic                 MemWrite_M,
    input  logic                 Branch_M,
    input  logic                 zero_M,
    input  logic [63:0]          aluResult_M,
    input  logic [63:0]          writeData_M,
    output logic [63:0]          readData_M,
    output logic                 PCSrc_M,
    output logic                 stall_M,
    output logic                 memDone_M,
    output logic                 misalign_M,
    output logic                 timeout_M,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic [63:0]          dm_wdata,
    input  logic                 dm_ack,
    input  logic [63:0]          dm_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [CNT_W-1:0]       count_r;
    logic                   access_s;
    logic                   misaligned_s;
    logic                   expire_s;
    logic [63:0]            read_data_r;
    logic                   mem_done_r;
    logic                   misalign_r;
    logic                   timeout_r;
    logic                   dm_req_r;
    logic                   dm_we_r;
    logic [DM_ADDR_W-1:0]   dm_addr_r;
    logic [63:0]            dm_wdata_r;
    logic                   unused_s;

    // Address bits above the doubleword index wrap away and are intentionally dropped.
    assign unused_s = ^aluResult_M[63:DM_ADDR_W+3];

    assign access_s     = MemRead_M | MemWrite_M;
    assign misaligned_s = |aluResult_M[2:0];
    // Last permitted REQ cycle: without an ack this cycle the access is abandoned.
    assign expire_s     = (count_r == CNT_LAST);

    assign PCSrc_M    = Branch_M & zero_M;
    assign readData_M = read_data_r;
    assign memDone_M  = mem_done_r;
    assign misalign_M = misalign_r;
    assign timeout_M  = timeout_r;
    assign dm_req     = dm_req_r;
    assign dm_we      = dm_we_r;
    assign dm_addr    = dm_addr_r;
    assign dm_wdata   = dm_wdata_r;

    // Stall is raised combinationally in the IDLE cycle that launches an aligned access,
    // held through REQ, and forced low while reset is asserted.
    assign stall_M = reset & ((state_r == ST_REQ) |
                              ((state_r == ST_IDLE) & access_s & ~misaligned_s));

    // Next-state logic for the IDLE/REQ/DONE access sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    if (misaligned_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_REQ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dm_ack || expire_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered bus signals, load data, wait counter and completion pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r     <= CNT_ZERO;
            read_data_r <= 64'd0;
            mem_done_r  <= 1'b0;
            misalign_r  <= 1'b0;
            timeout_r   <= 1'b0;
            dm_req_r    <= 1'b0;
            dm_we_r     <= 1'b0;
            dm_addr_r   <= {DM_ADDR_W{1'b0}};
            dm_wdata_r  <= 64'd0;
        end else begin
            mem_done_r <= 1'b0;
            misalign_r <= 1'b0;
            timeout_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    count_r <= CNT_ZERO;
                    if (access_s && misaligned_s) begin
                        mem_done_r <= 1'b1;
                        misalign_r <= 1'b1;
                    end else if (access_s) begin
                        // A simultaneous read and write is treated as a write.
                        dm_req_r   <= 1'b1;
                        dm_we_r    <= MemWrite_M;
                        dm_addr_r  <= aluResult_M[DM_ADDR_W+2:3];
                        dm_wdata_r <= writeData_M;
                    end
                end
                ST_REQ: begin
                    count_r <= count_r + CNT_ONE;
                    if (dm_ack) begin
                        dm_req_r   <= 1'b0;
                        mem_done_r <= 1'b1;
                        if (!dm_we_r) begin
                            read_data_r <= dm_rdata;
                        end
                    end else if (expire_s) begin
                        dm_req_r    <= 1'b0;
                        mem_done_r  <= 1'b1;
                        timeout_r   <= 1'b1;
                        read_data_r <= 64'd0;
                    end
                end
                ST_DONE: begin
                    count_r <= CNT_ZERO;
                end
                default: begin
                    count_r  <= CNT_ZERO;
                    dm_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized accesses
// compared against a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic        Branch_M;
    logic        zero_M;
    logic [63:0] aluResult_M;
    logic [63:0] writeData_M;
    logic [63:0] readData_M;
    logic        PCSrc_M;
    logic        stall_M;
    logic        memDone_M;
    logic        misalign_M;
    logic        timeout_M;
    logic        dm_req;
    logic        dm_we;
    logic [5:0]  dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_ack;
    logic [63:0] dm_rdata;

    int          checks;
    int          failures;
    logic [63:0] model_rd;

    mem_access_ctrl #(.DM_ADDR_W(6), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead_M   (MemRead_M),
        .MemWrite_M  (MemWrite_M),
        .Branch_M    (Branch_M),
        .zero_M      (zero_M),
        .aluResult_M (aluResult_M),
        .writeData_M (writeData_M),
        .readData_M  (readData_M),
        .PCSrc_M     (PCSrc_M),
        .stall_M     (stall_M),
        .memDone_M   (memDone_M),
        .misalign_M  (misalign_M),
        .timeout_M   (timeout_M),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"},   {63'd0, dm_req},     64'd0);
        check_val({tag, "_stall"}, {63'd0, stall_M},    64'd0);
        check_val({tag, "_done"},  {63'd0, memDone_M},  64'd0);
        check_val({tag, "_mis"},   {63'd0, misalign_M}, 64'd0);
        check_val({tag, "_to"},    {63'd0, timeout_M},  64'd0);
        check_val({tag, "_we"},    {63'd0, dm_we},      64'd0);
        check_val({tag, "_addr"},  {58'd0, dm_addr},    64'd0);
        check_val({tag, "_wdata"}, dm_wdata,            64'd0);
        check_val({tag, "_rdata"}, readData_M,          64'd0);
    endtask

    // One idle pipeline cycle: no access, nothing may stall or complete.
    task automatic idle_cycle();
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
        Branch_M   = 1'($urandom_range(0, 1));
        zero_M     = 1'($urandom_range(0, 1));
        dm_ack     = 1'($urandom_range(0, 1));
        #4;
        check_val("idle_stall", {63'd0, stall_M}, 64'd0);
        check_val("idle_req",   {63'd0, dm_req},  64'd0);
        check_val("idle_pcsrc", {63'd0, PCSrc_M}, {63'd0, Branch_M & zero_M});
        @(posedge clk);
        #1;
    endtask

    // One memory instruction. lat = number of REQ cycles the bus waits before acking,
    // so the ack arrives in REQ cycle lat+1; lat >= TIMEOUT means the bus never answers.
    task automatic run_txn(input logic rd, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input int lat);
        logic        mis;
        logic        exp_to;
        int          exp_req;
        int          exp_stall;
        logic [63:0] exp_addr;
        logic [63:0] rdat;
        int          req_cnt;
        int          stall_cnt;
        int          cyc;
        logic        done;

        mis       = (addr % 64'd8) != 64'd0;
        exp_to    = !mis && (lat + 1 > TIMEOUT);
        exp_req   = mis ? 0 : ((lat + 1 <= TIMEOUT) ? lat + 1 : TIMEOUT);
        exp_stall = mis ? 0 : exp_req + 1;
        exp_addr  = (addr / 64'd8) % 64'd64;
        req_cnt   = 0;
        stall_cnt = 0;
        cyc       = 0;
        done      = 1'b0;

        MemRead_M   = rd;
        MemWrite_M  = wr;
        aluResult_M = addr;
        writeData_M = wdata;
        while (!done && cyc < 60) begin
            rdat     = {$urandom, $urandom};
            dm_rdata = rdat;
            Branch_M = 1'($urandom_range(0, 1));
            zero_M   = 1'($urandom_range(0, 1));
            if (dm_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    check_val("req_addr",  {58'd0, dm_addr}, exp_addr);
                    check_val("req_we",    {63'd0, dm_we},   {63'd0, wr});
                    check_val("req_wdata", dm_wdata,         wdata);
                end
                dm_ack = (req_cnt == lat + 1);
                if (dm_ack && !wr) begin
                    model_rd = rdat;
                end
            end else begin
                // Acks outside an outstanding request must be ignored.
                dm_ack = 1'($urandom_range(0, 1));
            end
            #4;
            check_val("pcsrc", {63'd0, PCSrc_M}, {63'd0, Branch_M & zero_M});
            if (stall_M) begin
                stall_cnt++;
            end
            if (memDone_M) begin
                done = 1'b1;
                if (exp_to) begin
                    model_rd = 64'd0;
                end
                check_val("done_mis",   {63'd0, misalign_M}, {63'd0, mis});
                check_val("done_to",    {63'd0, timeout_M},  {63'd0, exp_to});
                check_val("done_rdata", readData_M,          model_rd);
                check_val("done_stall", {63'd0, stall_M},    64'd0);
                check_val("done_req",   {63'd0, dm_req},     64'd0);
            end else begin
                check_val("pulse_quiet", {62'd0, misalign_M, timeout_M}, 64'd0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val("done_seen", {63'd0, done},    64'd1);
        check_val("req_cycles", 64'(req_cnt),    64'(exp_req));
        check_val("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
        dm_ack     = 1'b0;
    endtask

    initial begin
        logic        rd;
        logic        wr;
        logic [63:0] a;
        int          lat;

        checks      = 0;
        failures    = 0;
        model_rd    = 64'd0;
        reset       = 1'b0;
        MemRead_M   = 1'b0;
        MemWrite_M  = 1'b0;
        Branch_M    = 1'b0;
        zero_M      = 1'b0;
        aluResult_M = 64'd0;
        writeData_M = 64'd0;
        dm_ack      = 1'b0;
        dm_rdata    = 64'd0;

        repeat (2) @(posedge clk);
        #2;
        check_all_zero("rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed: read, bus acks in the third REQ cycle, four stall cycles.
        dm_rdata = 64'hDEAD_BEEF;
        run_txn(1'b1, 1'b0, 64'h28, 64'd0, 2);
        // Directed: zero-wait write, readData_M keeps the previous load.
        run_txn(1'b0, 1'b1, 64'h10, 64'h1234, 0);
        // Directed: misaligned read, no bus request.
        run_txn(1'b1, 1'b0, 64'h0C, 64'd0, 0);
        // Directed: bus never answers.
        run_txn(1'b1, 1'b0, 64'h40, 64'd0, 100);
        // Directed: both read and write set behaves as a write.
        run_txn(1'b1, 1'b1, 64'h18, 64'hA5A5, 1);
        // Directed: branch select and address wrap.
        Branch_M = 1'b1;
        zero_M   = 1'b1;
        #1;
        check_val("pcsrc_taken", {63'd0, PCSrc_M}, 64'd1);
        zero_M = 1'b0;
        #1;
        check_val("pcsrc_not_taken", {63'd0, PCSrc_M}, 64'd0);
        @(posedge clk);
        #1;
        run_txn(1'b1, 1'b0, 64'h208, 64'd0, 1);

        // Directed: reset asserted in the second REQ cycle clears everything at once.
        MemRead_M   = 1'b1;
        aluResult_M = 64'h40;
        dm_ack      = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_val("pre_rst_req", {63'd0, dm_req}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        MemRead_M = 1'b0;
        model_rd  = 64'd0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomized accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) begin
                rd = 1'b1;
            end
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                a[2:0] = 3'b000;
            end
            if ($urandom_range(0, 7) == 0) begin
                lat = $urandom_range(TIMEOUT - 1, TIMEOUT + 4);
            end else begin
                lat = $urandom_range(0, 5);
            end
            run_txn(rd, wr, a, {$urandom, $urandom}, lat);
            if ($urandom_range(0, 2) == 0) begin
                idle_cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
